// File: rtl/if_fetch.sv
// Instruction fetch stage: issues in-order memory requests and
// buffers returned instructions for the IF/ID register.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        IF_stall,
    input  logic        IF_flush,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] PC_o,
    output logic [31:0] instruction_o,
    output logic        valid_o
);

    logic [31:0] pc_q;
    logic [31:0] fb_pc  [4];
    logic [31:0] fb_ins [4];
    logic [1:0]  head_q;
    logic [1:0]  tail_q;
    logic [2:0]  occ_q;
    logic [1:0]  live_q;
    logic [1:0]  drop_q;
    logic [31:0] pq [2];
    logic        pq_head_q;
    logic        pq_tail;

    logic        xfer;
    logic        resp_live;
    logic        resp_drop;
    logic        resp_any;
    logic        push;
    logic        pop;
    logic [3:0]  occ_live;
    logic [2:0]  live_drop;
    logic [31:0] pc_d;
    logic [2:0]  occ_d;
    logic [1:0]  live_d;
    logic [1:0]  drop_d;

    // Request gating and response classification from registered counts only.
    always_comb begin
        occ_live   = {1'b0, occ_q} + {2'b00, live_q};
        live_drop  = {1'b0, live_q} + {1'b0, drop_q};
        imem_req_o = rst_n && (occ_live < 4'd4) && (live_drop < 3'd2)
                     && !IF_flush;
        xfer       = imem_req_o && imem_ack_i;
        // A response with nothing outstanding is stray and ignored entirely.
        resp_drop  = imem_rvalid_i && (drop_q != 2'd0);
        resp_live  = imem_rvalid_i && (drop_q == 2'd0) && (live_q != 2'd0);
        resp_any   = resp_drop || resp_live;
        push       = resp_live && !IF_flush;
        pop        = (occ_q != 3'd0) && !IF_stall && !IF_flush;
        // New requests go behind the live entries of the PC queue.
        pq_tail    = pq_head_q ^ live_q[0];
    end

    // Next-state for fetch PC and the occupancy / outstanding counters.
    always_comb begin
        pc_d   = pc_q;
        occ_d  = occ_q;
        live_d = live_q;
        drop_d = drop_q;
        if (IF_flush) begin
            pc_d   = branch_target_i;
            occ_d  = 3'd0;
            live_d = 2'd0;
            // Everything still in flight, minus what returns now, is stale.
            drop_d = drop_q + live_q - {1'b0, resp_any};
        end else begin
            if (xfer) begin
                pc_d = pc_q + 32'd4;
            end
            occ_d  = occ_q + {2'b00, push} - {2'b00, pop};
            live_d = live_q + {1'b0, xfer} - {1'b0, resp_live};
            drop_d = drop_q - {1'b0, resp_drop};
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            occ_q     <= 3'd0;
            live_q    <= 2'd0;
            drop_q    <= 2'd0;
            head_q    <= 2'd0;
            tail_q    <= 2'd0;
            pq_head_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            occ_q  <= occ_d;
            live_q <= live_d;
            drop_q <= drop_d;
            if (IF_flush) begin
                head_q <= 2'd0;
                tail_q <= 2'd0;
            end else begin
                if (push) begin
                    tail_q <= tail_q + 2'd1;
                end
                if (pop) begin
                    head_q <= head_q + 2'd1;
                end
            end
            if (resp_live) begin
                pq_head_q <= ~pq_head_q;
            end
        end
    end

    // Fetch buffer and request-PC queue storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                fb_pc[i]  <= 32'd0;
                fb_ins[i] <= 32'd0;
            end
            pq[0] <= 32'd0;
            pq[1] <= 32'd0;
        end else begin
            if (push) begin
                fb_pc[tail_q]  <= pq[pq_head_q];
                fb_ins[tail_q] <= imem_rdata_i;
            end
            if (xfer) begin
                pq[pq_tail] <= pc_q;
            end
        end
    end

    // Head entry to the decode stage; bubble when the buffer is empty.
    always_comb begin
        valid_o       = (occ_q != 3'd0);
        imem_addr_o   = pc_q;
        PC_o          = valid_o ? fb_pc[head_q] : 32'd0;
        instruction_o = valid_o ? fb_ins[head_q] : 32'd0;
    end

endmodule
